// File: rtl/times_table_sequencer_if.sv
// Bus between the times-table sequencer and its environment: run control,
// multiplier operand/result lines, and the indexed product stream.
interface times_table_sequencer_if;
    logic       start;
    logic [2:0] table_sel;  // the run's multiplicand (`table` is a reserved word)
    logic [2:0] a;
    logic [2:0] b;
    logic       read;
    logic [5:0] result;
    logic       prod_valid;
    logic [2:0] prod_index;
    logic [5:0] prod_value;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [3:0] err_count;

    modport master (
        input  start, table_sel, result,
        output a, b, read, prod_valid, prod_index, prod_value,
               busy, done, mismatch, err_count
    );

    modport slave (
        output start, table_sel, result,
        input  a, b, read, prod_valid, prod_index, prod_value,
               busy, done, mismatch, err_count
    );
endinterface

// File: rtl/times_table_sequencer.sv
// Issues b=0..7 against a latched table to a multiplier, realigns the returned
// products with their index through a LATENCY-deep pipeline, and checks them.
module times_table_sequencer #(
    parameter int LATENCY = 1
) (
    input logic clk,
    input logic rst,
    times_table_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                      state, state_nx;
    logic [2:0]                  a_q, b_q;
    logic [LATENCY-1:0]          vld_pipe;
    logic [LATENCY-1:0][2:0]     idx_pipe;
    logic                        out_vld;
    logic [2:0]                  out_idx;
    logic [5:0]                  expect_prod;
    logic                        prod_valid_q, done_q, mismatch_q;
    logic [2:0]                  prod_index_q;
    logic [5:0]                  prod_value_q;
    logic [3:0]                  err_count_q;
    logic                        read_w;

    assign read_w      = (state == ISSUE);
    assign out_vld     = vld_pipe[LATENCY-1];
    assign out_idx     = idx_pipe[LATENCY-1];
    assign expect_prod = {3'b000, a_q} * {3'b000, out_idx};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ISSUE;
            ISSUE:   if (b_q == 3'd7) state_nx = DRAIN;
            // Leave only after the done cycle so a start during done is ignored.
            DRAIN:   if (done_q && vld_pipe == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            vld_pipe     <= '0;
            idx_pipe     <= '0;
            prod_valid_q <= 1'b0;
            prod_index_q <= '0;
            prod_value_q <= '0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state <= state_nx;
            // Wraps 7 -> 0 on the last issue cycle, and stays 0 elsewhere.
            b_q   <= read_w ? b_q + 3'd1 : 3'd0;

            if (state == IDLE && bus.start) begin
                a_q         <= bus.table_sel;
                mismatch_q  <= 1'b0;
                err_count_q <= '0;
            end

            vld_pipe[0] <= read_w;
            idx_pipe[0] <= b_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end

            prod_valid_q <= out_vld;
            done_q       <= out_vld && (out_idx == 3'd7);
            if (out_vld) begin
                prod_value_q <= bus.result;
                prod_index_q <= out_idx;
                if (bus.result != expect_prod) begin
                    mismatch_q  <= 1'b1;
                    err_count_q <= err_count_q + 4'd1;
                end
            end
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.read       = read_w;
    assign bus.busy       = (state != IDLE);
    assign bus.prod_valid = prod_valid_q;
    assign bus.prod_index = prod_index_q;
    assign bus.prod_value = prod_value_q;
    assign bus.done       = done_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_times_table_sequencer.sv
// Scoreboard bench: two sequencers (LATENCY 1 and 2) driving behavioural
// multipliers; runs push expected products, a negedge monitor pops and checks.
module tb_times_table_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    times_table_sequencer_if i0 ();
    times_table_sequencer_if i1 ();

    times_table_sequencer #(.LATENCY(1)) u0 (.clk(clk), .rst(rst), .bus(i0.master));
    times_table_sequencer #(.LATENCY(2)) u1 (.clk(clk), .rst(rst), .bus(i1.master));

    logic [1:0] st;
    logic [1:0] flt;
    logic [2:0] tsel [2];
    assign i0.start     = st[0];
    assign i1.start     = st[1];
    assign i0.table_sel = tsel[0];
    assign i1.table_sel = tsel[1];

    // Multiplier models; flt forces a zero product for b=5.
    logic [5:0] m0, m1a, m1b;
    always @(posedge clk) begin
        m0  <= (flt[0] && i0.b == 3'd5) ? 6'd0 : {3'b000, i0.a} * {3'b000, i0.b};
        m1a <= (flt[1] && i1.b == 3'd5) ? 6'd0 : {3'b000, i1.a} * {3'b000, i1.b};
        m1b <= m1a;
    end
    assign i0.result = m0;
    assign i1.result = m1b;

    logic [1:0] pv, dn, rd, bsy, mm;
    logic [2:0] pidx [2];
    logic [2:0] bo [2];
    logic [2:0] ao [2];
    logic [5:0] pval [2];
    logic [3:0] ec [2];
    assign pv  = {i1.prod_valid, i0.prod_valid};
    assign dn  = {i1.done, i0.done};
    assign rd  = {i1.read, i0.read};
    assign bsy = {i1.busy, i0.busy};
    assign mm  = {i1.mismatch, i0.mismatch};
    assign pidx[0] = i0.prod_index;  assign pidx[1] = i1.prod_index;
    assign bo[0]   = i0.b;           assign bo[1]   = i1.b;
    assign ao[0]   = i0.a;           assign ao[1]   = i1.a;
    assign pval[0] = i0.prod_value;  assign pval[1] = i1.prod_value;
    assign ec[0]   = i0.err_count;   assign ec[1]   = i1.err_count;

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic [5:0] val;
        logic       mm;
        logic [3:0] ec;
        logic       dn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdc [2];
    int dnc [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rd[d]) rdc[d]++;
            if (dn[d]) begin
                dnc[d]++;
                chk($sformatf("d%0d done_with_valid", d), int'(pv[d]), 1);
            end
            if (pv[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("d%0d unexpected_prod", d), 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("d%0d prod_cycle", d), cyc, e.cyc);
                    chk($sformatf("d%0d prod_index", d), int'(pidx[d]), int'(e.idx));
                    chk($sformatf("d%0d prod_value", d), int'(pval[d]), int'(e.val));
                    chk($sformatf("d%0d mismatch", d), int'(mm[d]), int'(e.mm));
                    chk($sformatf("d%0d err_count", d), int'(ec[d]), int'(e.ec));
                    chk($sformatf("d%0d done", d), int'(dn[d]), int'(e.dn));
                end
            end
        end
    end

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic run(input int d, input logic [2:0] t, input logic f,
                       input logic ign, output int n);
        exp_t e;
        int   lat;
        lat = (d == 0) ? 1 : 2;
        n = cyc;
        flt[d] = f; st[d] = 1'b1; tsel[d] = t; rdc[d] = 0; dnc[d] = 0;
        for (int k = 0; k < 8; k++) begin
            e.cyc = n + k + 2 + lat;
            e.idx = 3'(k);
            e.val = (f && k == 5) ? 6'd0 : {3'b000, t} * 6'(k);
            e.mm  = f && k >= 5;
            e.ec  = (f && k >= 5) ? 4'd1 : 4'd0;
            e.dn  = (k == 7);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        st[d] = 1'b0;
        chk("c1_busy", int'(bsy[d]), 1);
        chk("c1_read", int'(rd[d]), 1);
        chk("c1_b", int'(bo[d]), 0);
        chk("c1_a", int'(ao[d]), int'(t));
        chk("c1_mismatch_clr", int'(mm[d]), 0);
        chk("c1_err_clr", int'(ec[d]), 0);
        if (ign) begin
            repeat (3) @(negedge clk);
            st[d] = 1'b1; tsel[d] = ~t;
            @(negedge clk);
            st[d] = 1'b0;
            repeat (4) @(negedge clk);
            st[d] = 1'b1;
            @(negedge clk);
            st[d] = 1'b0;
        end
    endtask

    // Returns at the first negedge with busy low.
    task automatic wait_idle(input int d, input int n, input int lat);
        int k;
        k = 0;
        while (bsy[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_cycle", cyc - n, 10 + lat);
        chk("read_cycles", rdc[d], 8);
        chk("done_count", dnc[d], 1);
        chk("queue_empty", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic chk_zero(input int d);
        chk("z_a", int'(ao[d]), 0);
        chk("z_b", int'(bo[d]), 0);
        chk("z_read", int'(rd[d]), 0);
        chk("z_busy", int'(bsy[d]), 0);
        chk("z_pv", int'(pv[d]), 0);
        chk("z_done", int'(dn[d]), 0);
        chk("z_mm", int'(mm[d]), 0);
        chk("z_ec", int'(ec[d]), 0);
        chk("z_pval", int'(pval[d]), 0);
        chk("z_pidx", int'(pidx[d]), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; st = '0; flt = '0; tsel[0] = '0; tsel[1] = '0;
        repeat (2) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        @(negedge clk);

        run(0, 3'd3, 1'b0, 1'b0, n); wait_idle(0, n, 1);
        chk("t3_mismatch", int'(mm[0]), 0);
        run(0, 3'd7, 1'b0, 1'b0, n); wait_idle(0, n, 1);
        chk("t7_err", int'(ec[0]), 0);
        run(0, 3'd0, 1'b0, 1'b0, n); wait_idle(0, n, 1);
        chk("t0_err", int'(ec[0]), 0);

        run(0, 3'd3, 1'b1, 1'b0, n); wait_idle(0, n, 1);
        chk("fault_mm_hold", int'(mm[0]), 1);
        chk("fault_ec_hold", int'(ec[0]), 1);

        // Next start clears the flags; stray starts mid-run are ignored.
        run(0, 3'd3, 1'b0, 1'b1, n); wait_idle(0, n, 1);
        chk("ign_a_kept", int'(ao[0]), 3);

        run(0, 3'd3, 1'b0, 1'b0, n);
        repeat (4) @(negedge clk);
        chk("pre_rst_b", int'(bo[0]), 4);
        #2 rst = 1'b1;
        #1;
        chk_zero(0);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        dnc[0] = 0;
        repeat (10) @(negedge clk);
        chk("post_rst_done", dnc[0], 0);
        chk("post_rst_busy", int'(bsy[0]), 0);
        run(0, 3'd6, 1'b0, 1'b0, n); wait_idle(0, n, 1);

        run(1, 3'd5, 1'b0, 1'b0, n); wait_idle(1, n, 2);
        chk("l2_busy_c12", int'(bsy[1]), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/times_table_sequencer.md
# times_table_sequencer

Operand sequencer and result collector sitting directly upstream of the `multiplication` times-table block. On a start request it drives `a` (the selected table) and `b` (0..7) with the `read` strobe into the multiplier, one operand pair per cycle. It aligns each returned `result` with its `b` index through a latency pipeline and presents the indexed products downstream. It self-checks every product against `a*b` and reports a sticky mismatch flag and count.

## Interface
- `LATENCY`, default 1: cycles from a `read`-high cycle to the corresponding `result` being valid on the input (1..4 supported).
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a table run; sampled only in IDLE.
- `table`  in  3  multiplicand for the run; latched on accepted `start`.
- `a`  out  3  multiplicand to the multiplier; holds the latched table.
- `b`  out  3  multiplier operand to the multiplier.
- `read`  out  1  read strobe to the multiplier.
- `result`  in  6  product returned by the multiplier.
- `prod_valid`  out  1  `prod_index`/`prod_value` valid this cycle.
- `prod_index`  out  3  `b` value the product belongs to.
- `prod_value`  out  6  captured product.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse with the final product.
- `mismatch`  out  1  sticky: at least one product differed from `a*b` in this run.
- `err_count`  out  4  number of mismatching products this run (0..8).

## Operation
- Reset values: all outputs 0; state IDLE; latency pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `start`=1 latches `table` into `a`, clears `mismatch` and `err_count`, loads `b`=0, and moves to ISSUE.
  - ISSUE: `read`=1 and `b` increments each cycle. The cycle with `b`=7 moves to DRAIN.
  - DRAIN: `read`=0 and `b`=0. When the pipeline holds no pending entries and the last product has been captured, return to IDLE.
- Latency pipeline: a `LATENCY`-deep shift register of {valid, index}. It is loaded with {`read`, `b`} every cycle.
- Capture: when the pipeline output is valid, register `prod_value`=`result`, `prod_index`=index, and `prod_valid`=1.
- Check: compare against the 6-bit zero-extended product `a*index` (max 49). On inequality set `mismatch` and increment `err_count`. `err_count` cannot exceed 8, so there is no wrap.
- `start` in ISSUE or DRAIN is ignored. `table` changes mid-run are ignored.
- Outside ISSUE, `b`=0 and `read`=0. `a` holds its last latched value in IDLE.

## Timing
- Let edge E0 be the edge that accepts `start`.
- ISSUE occupies cycles 1..8, where cycle k+1 carries `b`=k.
- `read` is high for exactly 8 consecutive cycles.
- The multiplier presents the product for `b`=k in cycle k+1+`LATENCY`. The block registers it, so `prod_valid` for index k is high in cycle k+2+`LATENCY`.
- With `LATENCY`=1, products appear in cycles 3..10 on consecutive cycles, indices 0..7 in order.
- `done`=1 in the same cycle as `prod_valid` for index 7, which is cycle 10 for `LATENCY`=1.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low the cycle after.
- `mismatch` and `err_count` reflect a product in the same cycle as its `prod_valid`. They hold after `done` until the next accepted `start`.
- Back-to-back runs: `start` held high in the cycle after `done` is accepted. Its first `read` cycle follows the next edge.
- Reset mid-run: all outputs go to 0 immediately and the state returns to IDLE. `result` values still in flight are ignored, with no `prod_valid` and no `done`.

## Test plan
- `table`=3, correct multiplier, `LATENCY`=1 → `prod_value` 0,3,6,...,21 on indices 0..7 in cycles 3..10; `done` only in cycle 10; `mismatch`=0.
- `table`=7 → index 7 gives 49 (6'b110001); `table`=0 → all eight products 0; `err_count`=0 in both cases.
- Faulty model with `table`=3 that returns 0 when `b`=5 → `mismatch` rises in the index-5 `prod_valid` cycle; `err_count`=1 at `done`; both are cleared by the next `start`.
- Pulse `start` in cycles 4 and 9 of a run → ignored: exactly 8 `read` cycles, one `done`, `a` unchanged.
- Assert `rst` asynchronously mid-cycle while `b`=4 → all outputs 0 before the next edge; no further `prod_valid` or `done`; a new `start` then completes a full run normally.
- `LATENCY`=2 with a matching 2-cycle model, `table`=5 → products 0..35 in cycles 4..11; `done` in cycle 11; `busy` low in cycle 12.
